result_tile_reader: RTL and testbench

- Read-side counterpart of the result accumulator.
- Sweeps one BLOCK_SIZE x BLOCK_SIZE tile of the MATRIX_SIZE x MATRIX_SIZE result storage through a synchronous read port.
- Streams the elements out on a valid/ready interface, row-major, for host/DMA drain.
- Sits between the result storage and the output DMA. A small output buffer absorbs the read latency and backpressure without losing elements or throughput.

---
 rtl/result_tile_reader.sv | 172 +++++++++++++++++
 tb/tb_result_tile_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_tile_reader.sv
// Streams one BLOCK_SIZE x BLOCK_SIZE tile out of the result storage over valid/ready.
// Define RESULT_TILE_READER_TRANSPOSE_EN to emit the tile column-major (transposed).
module result_tile_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int BLOCK_SIZE  = 64,
  parameter int MATRIX_SIZE = 128,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            row_block_idx,
  input  logic [1:0]            col_block_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last_row,
  output logic                  m_last
);

  localparam int BW = $clog2(BLOCK_SIZE);
  localparam int MW = $clog2(MATRIX_SIZE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            rblk_q, cblk_q;
  logic [BW-1:0]         inner_q, outer_q;
  logic [BW-1:0]         r_cur, c_cur;
  logic [MW-1:0]         row_full, col_full;
  logic                  infl_q, infl_last_row_q, infl_last_q;
  logic                  done_q, err_q, done_d, err_d, start_ok;
  logic                  range_bad, issue_last_row, issue_last, pop, can_issue;
  logic [2:0]            pending;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_lr   [2];
  logic                  fifo_last [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  // inner counter runs fastest; the build option picks whether it walks columns or rows
`ifdef RESULT_TILE_READER_TRANSPOSE_EN
  assign r_cur = inner_q;
  assign c_cur = outer_q;
`else
  assign r_cur = outer_q;
  assign c_cur = inner_q;
`endif

  assign row_full = MW'(int'(rblk_q) * BLOCK_SIZE) + MW'(r_cur);
  assign col_full = MW'(int'(cblk_q) * BLOCK_SIZE) + MW'(c_cur);
  assign rd_addr  = ADDR_WIDTH'({row_full, col_full});

  assign range_bad = (int'(row_block_idx) * BLOCK_SIZE >= MATRIX_SIZE) ||
                     (int'(col_block_idx) * BLOCK_SIZE >= MATRIX_SIZE);
  assign issue_last_row = (inner_q == '1);
  assign issue_last     = issue_last_row && (outer_q == '1);

  assign m_valid    = (count_q != 2'd0);
  assign m_data     = fifo_data[rd_ptr_q];
  assign m_last_row = m_valid & fifo_lr[rd_ptr_q];
  assign m_last     = m_valid & fifo_last[rd_ptr_q];
  assign pop        = m_valid & m_ready;

  // credit: buffered + in-flight, less what leaves this cycle, must leave room for one more
  assign pending   = {1'b0, count_q} + {2'b00, infl_q};
  assign can_issue = pending < (3'd2 + {2'b00, pop});

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    start_ok = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_d  = READ;
          end
        end
      end
      READ: begin
        if (can_issue) begin
          rd_en = 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rblk_q          <= '0;
      cblk_q          <= '0;
      inner_q         <= '0;
      outer_q         <= '0;
      infl_q          <= 1'b0;
      infl_last_row_q <= 1'b0;
      infl_last_q     <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q          <= done_d;
      err_q           <= err_d;
      infl_q          <= rd_en;
      infl_last_row_q <= rd_en & issue_last_row;
      infl_last_q     <= rd_en & issue_last;
      if (start_ok) begin
        rblk_q  <= row_block_idx;
        cblk_q  <= col_block_idx;
        inner_q <= '0;
        outer_q <= '0;
      end else if (rd_en) begin
        inner_q <= inner_q + BW'(1);
        if (inner_q == '1) outer_q <= outer_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_lr[i]   <= 1'b0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (infl_q) begin
        fifo_data[wr_ptr_q] <= rd_data;
        fifo_lr[wr_ptr_q]   <= infl_last_row_q;
        fifo_last[wr_ptr_q] <= infl_last_q;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({infl_q, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_result_tile_reader.sv
// Randomized-backpressure bench for result_tile_reader against a queue-based tile model.
module tb_result_tile_reader;

  localparam int DW  = 16;
  localparam int BS  = 64;
  localparam int MS  = 128;
  localparam int AW  = 14;
  localparam int NEL = BS * BS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    row_block_idx = '0;
  logic [1:0]    col_block_idx = '0;
  logic          busy, done, err, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last_row, m_last;

  result_tile_reader #(
    .DATA_WIDTH (DW),
    .BLOCK_SIZE (BS),
    .MATRIX_SIZE(MS),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .row_block_idx(row_block_idx),
    .col_block_idx(col_block_idx),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last_row   (m_last_row),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  // storage: each word holds its own address, one-cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr);

  typedef struct packed {
    logic [15:0] data;
    logic        lr;
    logic        last;
  } elem_t;

  elem_t       exp_q[$];
  int          n_vec = 0, n_bad = 0;
  int unsigned cyc = 0, start_edge = 0;
  int          tiles_done = 0, errs_seen = 0, acc_count = 0;
  bit          m_busy = 0, m_done = 0, m_err = 0;
  bit          check_lat = 0, first_pending = 0, prev_stall = 0;
  bit          ready_mode = 1;
  logic [15:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic elem_t model_elem(input int rb, input int cb, input int k);
    elem_t e;
    int fast, slow, row, col;
    fast = k % BS;
    slow = k / BS;
`ifdef RESULT_TILE_READER_TRANSPOSE_EN
    row = rb * BS + fast;
    col = cb * BS + slow;
`else
    row = rb * BS + slow;
    col = cb * BS + fast;
`endif
    e.data = 16'(row * MS + col);
    e.lr   = (fast == BS - 1);
    e.last = (k == NEL - 1);
    return e;
  endfunction

  function automatic bit idx_bad(input int rb, input int cb);
    return (rb * BS >= MS) || (cb * BS >= MS);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit    accept, last_acc, n_busy, n_done, n_err;
    elem_t head;
    if (!rst_n) begin
      chk("reset_flags", {busy, done, err, rd_en, m_valid, m_last_row, m_last}, '0);
      chk("reset_rd_addr", rd_addr, '0);
      chk("reset_m_data", m_data, '0);
      m_busy = 0; m_done = 0; m_err = 0;
      first_pending = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("rd_en_while_idle", rd_en & ~m_busy, 0);
      chk("valid_while_idle", m_valid & ~m_busy, 0);
      chk("fifo_occupancy_le2", dut.count_q <= 2'd2, 1);
      if (prev_stall) chk("held_while_stalled", {m_valid, m_data}, {1'b1, prev_data});
      if (m_done) begin
        tiles_done++;
        chk("elements_left_at_done", exp_q.size(), 0);
        if (check_lat) chk("start_to_done_cycles", cyc - start_edge + 1, NEL + 3);
      end
      if (m_err) errs_seen++;
      if (first_pending && m_valid) begin
        chk("first_valid_latency", cyc - start_edge, 2);
        first_pending = 0;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_element: got 0x%0h, expected no element", m_data);
        end else begin
          head = exp_q[0];
          chk("element", {m_data, m_last_row, m_last}, {head.data, head.lr, head.last});
        end
      end
      accept   = m_valid && m_ready && (exp_q.size() > 0);
      last_acc = accept && exp_q[0].last;
      if (accept) begin
        void'(exp_q.pop_front());
        acc_count++;
      end
      n_err  = !m_busy && start && idx_bad(row_block_idx, col_block_idx);
      n_done = m_busy && last_acc;
      n_busy = m_busy && !last_acc;
      if (!m_busy && start && !idx_bad(row_block_idx, col_block_idx)) begin
        for (int k = 0; k < NEL; k++) exp_q.push_back(model_elem(row_block_idx, col_block_idx, k));
        start_edge    = cyc + 1;
        first_pending = check_lat;
        n_busy        = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      m_busy = n_busy; m_done = n_done; m_err = n_err;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = ready_mode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic start_tile(input int rb, input int cb);
    @(posedge clk);
    #1;
    row_block_idx = 2'(rb);
    col_block_idx = 2'(cb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int budget, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (tiles_done != t0) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: no done within %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic run_tile(input int rb, input int cb, input string name);
    int t0;
    t0 = tiles_done;
    start_tile(rb, cb);
    wait_done(t0, 20000, name);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_accepted(input int target, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(posedge clk);
      if (acc_count >= target) ok = 1;
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d accepted, expected %0d", name, acc_count, target);
    end
  endtask

  initial begin
    int t0, e0, a0;
    elem_t e;
    // model pins, hand-computed from row*128+col
`ifdef RESULT_TILE_READER_TRANSPOSE_EN
    e = model_elem(0, 0, 1);    chk("pin_t00_k1", e.data, 16'h0080);
    e = model_elem(0, 0, 2);    chk("pin_t00_k2", e.data, 16'h0100);
    e = model_elem(1, 1, 63);   chk("pin_t11_k63", {e.data, e.lr}, {16'h3FC0, 1'b1});
`else
    e = model_elem(0, 0, 64);   chk("pin_00_k64", e.data, 16'h0080);
    e = model_elem(0, 0, 63);   chk("pin_00_k63", {e.data, e.lr}, {16'h003F, 1'b1});
    e = model_elem(1, 1, 63);   chk("pin_11_k63", {e.data, e.lr}, {16'h207F, 1'b1});
`endif
    e = model_elem(0, 0, 0);       chk("pin_00_first", e.data, 16'h0000);
    e = model_elem(0, 0, NEL - 1); chk("pin_00_last", {e.data, e.last}, {16'h1FBF, 1'b1});
    e = model_elem(1, 1, 0);       chk("pin_11_first", e.data, 16'h2040);
    e = model_elem(1, 1, NEL - 1); chk("pin_11_last", {e.data, e.last}, {16'h3FFF, 1'b1});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    ready_mode = 1; check_lat = 1;
    run_tile(0, 0, "tile_00_full_rate");
    run_tile(1, 1, "tile_11_full_rate");

    // backpressure, with a second start mid-stream that must be ignored
    ready_mode = 0; check_lat = 0;
    t0 = tiles_done;
    a0 = acc_count;
    start_tile(0, 1);
    wait_accepted(a0 + 500, "reach_500_accepted");
    start_tile(1, 1);
    wait_done(t0, 20000, "tile_01_backpressure");
    repeat (3) @(posedge clk);

    e0 = errs_seen;
    t0 = tiles_done;
    start_tile(2, 0);
    repeat (5) @(posedge clk);
    start_tile(0, 3);
    repeat (5) @(posedge clk);
    chk("err_pulses", errs_seen - e0, 2);
    chk("no_done_on_err", tiles_done - t0, 0);
    run_tile(0, 0, "tile_00_after_err");

    // reset in the middle of a tile
    a0 = acc_count;
    start_tile(1, 0);
    wait_accepted(a0 + 100, "reach_100_accepted");
    @(posedge clk);
    #1 rst_n = 1'b0;
    t0 = tiles_done;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_done_after_reset", tiles_done - t0, 0);
    ready_mode = 1; check_lat = 1;
    repeat (2) @(posedge clk);
    run_tile(0, 0, "tile_00_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
